dram_responder: RTL and testbench
=================================

// Module: dram_responder
// PURPOSE
// - Memory-side responder for the MEM stage's data-RAM interface: accepts word-address requests, returns the raw 32-bit read word, performs stores.
// - MEM stage issues word address, lane-shifted store data and access size; lane extraction and sign extension of loads stay in MEM.
// - Sub-word stores use read-modify-write; programmable wait states model slow external RAM so the pipeline suspend logic can be exercised.
// PARAMETERS
// - ADDR_W    14  word-address width; depth = 2**ADDR_W words (64KB at default)
// - WAIT_CYC  1   wait-state cycles inserted before array access, 0..15
// PORTS
// - clk_i   in   1       clock; all state updates on posedge
// - reset_i in   1       asynchronous, active-high reset
// - req_i   in   1       request strobe; sampled only in IDLE
// - we_i    in   1       1 = store, 0 = load
// - adr_i   in   ADDR_W  word address (byte address [15:2])
// - off_i   in   2       byte offset within word (byte address [1:0])
// - size_i  in   2       00 byte, 01 half, 11 word; 10 reserved, treated as word
// - wd_i    in   32      store data, already shifted into its byte lanes
// - rd_o    out  32      raw read word, registered; valid while ack_o=1 and held after
// - ack_o   out  1       one-cycle completion pulse
// - busy_o  out  1       1 in every state except IDLE; drives pipeline suspend
// - err_o   out  1       misaligned-access flag, valid with ack_o (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async): state IDLE, ack_o=0, busy_o=0, err_o=0, rd_o=32'h0, wait counter 0. Array contents not cleared.
// - FSM states: IDLE, WAIT, ACCESS, MERGE, DONE.
// - IDLE: req_i=1 latches we, adr, off, size, wd into a request register.
//   - WAIT_CYC>0: go to WAIT, counter=WAIT_CYC-1.
//   - WAIT_CYC=0: go to ACCESS.
//   - Input changes after acceptance are ignored.
// - WAIT: counter decrements each cycle; at counter==0 go to ACCESS.
// - ACCESS: reads mem[adr] into the read buffer.
//   - Load: rd_o <= word, go to DONE.
//   - Word store: mem[adr] <= wd, go to DONE.
//   - Byte/half store: go to MERGE.
// - MERGE: mem[adr] <= buffer with selected lanes replaced from wd, then go to DONE.
//   - Byte: replace lane off.
//   - Half: replace lanes {off[1],0} and {off[1],1}.
// - DONE: ack_o=1 for exactly this cycle; next state IDLE. A req_i held high is accepted again in that IDLE cycle.
// - Latency, with req accepted in cycle 0:
//   - Load / word store: ack_o in cycle WAIT_CYC+2.
//   - Sub-word store: ack_o in cycle WAIT_CYC+3.
// - Stores leave rd_o unchanged. req_i outside IDLE is ignored; no queueing.
// - Reset mid-transaction aborts it; the array is written only at the ACCESS/MERGE clock edge, never partially.
// - Address is taken modulo depth, so no out-of-range access exists.
// CONFIGURATION
// - Macro MISALIGN_CHK_EN defined:
//   - A half access with off_i[0]=1, or a word access with off_i!=0, skips WAIT/ACCESS/MERGE and goes IDLE->DONE.
//   - ack_o=1 and err_o=1 in that DONE cycle; memory and rd_o unchanged.
//   - err_o=0 on every other ack.
// - Macro not defined: err_o tied 0.
//   - Word ignores off_i.
//   - Half uses off_i[1] only.
//   - All requests execute normally.
// TESTING
// - WAIT_CYC=1: word store adr=5 wd=32'hDEADBEEF, then load adr=5 -> each ack_o in cycle 3; rd_o=32'hDEADBEEF; busy_o=1 in cycles 1..3.
// - mem[7]=32'h11223344; byte store adr=7 off=2 wd=32'h00AA0000 -> ack in cycle 4; reload gives 32'h11AA3344.
// - mem[7]=32'h11223344; half store adr=7 off=2 wd=32'hBEEF0000 -> reload 32'hBEEF3344; off=0 wd=32'h0000CAFE -> 32'h1122CAFE.
// - WAIT_CYC=0 with req_i held high over two loads -> acks in cycles 2 and 5; req pulses during busy are ignored.
// - reset_i pulse during WAIT of a store to adr=9 (old 32'h0) -> outputs zero immediately; mem[9] still 32'h0.
// - MISALIGN_CHK_EN: word store off=1 -> ack+err in cycle 1, memory unchanged; without macro -> store completes, err_o=0.

Source files
------------

// File: rtl/dram_responder.sv
// Data-RAM responder for the MEM stage: word loads, word stores, read-modify-write sub-word stores.
// Optional misaligned-access trap enabled by defining MISALIGN_CHK_EN.
module dram_responder #(
    parameter int ADDR_W   = 14,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [1:0]        off_i,
    input  logic [1:0]        size_i,
    input  logic [31:0]       wd_i,
    output logic [31:0]       rd_o,
    output logic              ack_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_MERGE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam bit         HAS_WAIT  = (WAIT_CYC > 0);
    localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(WAIT_CYC - 1) : 4'd0;
    localparam int         DEPTH     = 1 << ADDR_W;

    logic [31:0]       mem [0:DEPTH-1];

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [3:0]        cnt;

    logic              q_we;
    logic [ADDR_W-1:0] q_adr;
    logic [1:0]        q_off;
    logic [1:0]        q_size;
    logic [31:0]       q_wd;
    logic [31:0]       rbuf;

    logic              misalign;
    logic              q_word;
    logic [3:0]        lane;
    logic [31:0]       bmask;
    logic [31:0]       merged;
    logic              mem_we;
    logic [31:0]       mem_wd;

    // Size code 10 is reserved and behaves as a full word.
    assign q_word = q_size[1];

`ifdef MISALIGN_CHK_EN
    logic q_err;

    assign misalign = ((size_i == 2'b01) && off_i[0])
                    || (size_i[1] && (off_i != 2'b00));
    assign err_o    = (state == S_DONE) && q_err;
`else
    assign misalign = 1'b0;
    assign err_o    = 1'b0;
`endif

    assign ack_o  = (state == S_DONE);
    assign busy_o = (state != S_IDLE);

    always_comb begin
        lane = 4'b0000;
        unique case (q_size)
            2'b00:   lane[q_off] = 1'b1;
            2'b01:   lane = q_off[1] ? 4'b1100 : 4'b0011;
            default: lane = 4'b1111;
        endcase
    end

    assign bmask  = {{8{lane[3]}}, {8{lane[2]}}, {8{lane[1]}}, {8{lane[0]}}};
    assign merged = (rbuf & ~bmask) | (q_wd & bmask);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (req_i) begin
                    if (misalign)
                        state_nx = S_DONE;
                    else if (HAS_WAIT)
                        state_nx = S_WAIT;
                    else
                        state_nx = S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0)
                    state_nx = S_ACCESS;
            end
            S_ACCESS: begin
                if (q_we && !q_word)
                    state_nx = S_MERGE;
                else
                    state_nx = S_DONE;
            end
            S_MERGE: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            rd_o   <= 32'h0;
            rbuf   <= 32'h0;
            q_we   <= 1'b0;
            q_adr  <= '0;
            q_off  <= 2'b00;
            q_size <= 2'b00;
            q_wd   <= 32'h0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (req_i) begin
                        q_we   <= we_i;
                        q_adr  <= adr_i;
                        q_off  <= off_i;
                        q_size <= size_i;
                        q_wd   <= wd_i;
                        cnt    <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                end
                S_ACCESS: begin
                    rbuf <= mem[q_adr];
                    if (!q_we)
                        rd_o <= mem[q_adr];
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_CHK_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            q_err <= 1'b0;
        else if ((state == S_IDLE) && req_i)
            q_err <= misalign;
    end
`endif

    // Gated by reset so an edge coinciding with reset never commits a write.
    assign mem_we = !reset_i
                 && (((state == S_ACCESS) && q_we && q_word)
                  || (state == S_MERGE));
    assign mem_wd = (state == S_MERGE) ? merged : q_wd;

    always_ff @(posedge clk_i) begin
        if (mem_we)
            mem[q_adr] <= mem_wd;
    end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: vector table with scoreboard on a WAIT_CYC=1 instance,
// plus hand sequences for reset abort and held/pulsed requests on a WAIT_CYC=0 instance.
module tb_dram_responder;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we;
    logic [AW-1:0] adr;
    logic [1:0]    off, size;
    logic [31:0]   wd, rd;
    logic          ack, busy, err;

    logic          req0, we0;
    logic [AW-1:0] adr0;
    logic [1:0]    off0, size0;
    logic [31:0]   wd0, rd0;
    logic          ack0, busy0, err0;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] hold = 32'h0;

    always #5 clk = ~clk;

    dram_responder #(.ADDR_W(AW), .WAIT_CYC(1)) dut (
        .clk_i(clk), .reset_i(rst), .req_i(req), .we_i(we),
        .adr_i(adr), .off_i(off), .size_i(size), .wd_i(wd),
        .rd_o(rd), .ack_o(ack), .busy_o(busy), .err_o(err)
    );

    dram_responder #(.ADDR_W(AW), .WAIT_CYC(0)) dut0 (
        .clk_i(clk), .reset_i(rst), .req_i(req0), .we_i(we0),
        .adr_i(adr0), .off_i(off0), .size_i(size0), .wd_i(wd0),
        .rd_o(rd0), .ack_o(ack0), .busy_o(busy0), .err_o(err0)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [1:0]    off;
        logic [1:0]    size;
        logic [31:0]   wd;
        logic [31:0]   rd;
        int            lat;
        logic          err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        int          lat;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input int a, input logic [1:0] o,
                                input logic [1:0] s, input logic [31:0] d,
                                input logic [31:0] r, input int l, input logic e);
        vec_t v;
        v.we = w; v.adr = AW'(a); v.off = o; v.size = s;
        v.wd = d; v.rd = r; v.lat = l; v.err = e;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        exp_t e;
        int   n;
        logic bz;
        e.rd  = v.we ? hold : v.rd;
        e.lat = v.lat;
        e.err = v.err;
        sb.push_back(e);
        @(posedge clk); #1;
        req = 1'b1; we = v.we; adr = v.adr;
        off = v.off; size = v.size; wd = v.wd;
        n  = 0;
        bz = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
            req  = 1'b0;
            we   = 1'($urandom);
            adr  = AW'($urandom);
            off  = 2'($urandom);
            size = 2'($urandom);
            wd   = $urandom;
            if (!busy) bz = 1'b0;
        end while (!ack && n < 40);
        e = sb.pop_front();
        chk("latency", 32'(n), 32'(e.lat));
        chk("rd", rd, e.rd);
        chk("err", {31'h0, err}, {31'h0, e.err});
        @(posedge clk); #1;
        if (busy) bz = 1'b0;
        chk("busy", {31'h0, bz}, 32'h1);
        if (!v.we && !e.err) hold = v.rd;
    endtask

    task automatic wait0(inout int n);
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack0 && n < 20);
    endtask

    initial begin
        int n;
        int acks;

        rst = 1'b1;
        req = 1'b0; we = 1'b0; adr = '0; off = 2'b00; size = 2'b00; wd = 32'h0;
        req0 = 1'b0; we0 = 1'b0; adr0 = '0; off0 = 2'b00; size0 = 2'b00; wd0 = 32'h0;

        tbl.push_back(mk(1, 5, 0, 3, 32'hDEADBEEF, 0, 3, 0));
        tbl.push_back(mk(0, 5, 0, 3, 0, 32'hDEADBEEF, 3, 0));
        tbl.push_back(mk(1, 7, 0, 3, 32'h11223344, 0, 3, 0));
        tbl.push_back(mk(1, 7, 2, 0, 32'h00AA0000, 0, 4, 0));
        tbl.push_back(mk(0, 7, 0, 3, 0, 32'h11AA3344, 3, 0));
        tbl.push_back(mk(1, 7, 0, 3, 32'h11223344, 0, 3, 0));
        tbl.push_back(mk(1, 7, 2, 1, 32'hBEEF0000, 0, 4, 0));
        tbl.push_back(mk(0, 7, 0, 3, 0, 32'hBEEF3344, 3, 0));
        tbl.push_back(mk(1, 7, 0, 3, 32'h11223344, 0, 3, 0));
        tbl.push_back(mk(1, 7, 0, 1, 32'h0000CAFE, 0, 4, 0));
        tbl.push_back(mk(0, 7, 0, 3, 0, 32'h1122CAFE, 3, 0));
        tbl.push_back(mk(1, 7, 3, 0, 32'h55000000, 0, 4, 0));
        tbl.push_back(mk(1, 7, 0, 0, 32'h00000077, 0, 4, 0));
        tbl.push_back(mk(0, 7, 0, 3, 0, 32'h5522CA77, 3, 0));
        tbl.push_back(mk(0, 5, 0, 3, 0, 32'hDEADBEEF, 3, 0));
`ifdef MISALIGN_CHK_EN
        tbl.push_back(mk(1, 5, 1, 3, 32'h12345678, 0, 1, 1));
        tbl.push_back(mk(0, 5, 0, 3, 0, 32'hDEADBEEF, 3, 0));
        tbl.push_back(mk(1, 7, 1, 1, 32'h0000ABCD, 0, 1, 1));
        tbl.push_back(mk(0, 7, 0, 2, 0, 32'h5522CA77, 3, 0));
`else
        tbl.push_back(mk(1, 5, 1, 3, 32'h12345678, 0, 3, 0));
        tbl.push_back(mk(0, 5, 0, 3, 0, 32'h12345678, 3, 0));
        tbl.push_back(mk(1, 7, 1, 1, 32'h0000ABCD, 0, 4, 0));
        tbl.push_back(mk(0, 7, 0, 2, 0, 32'h5522ABCD, 3, 0));
`endif
        tbl.push_back(mk(1, 9, 0, 3, 32'h00000000, 0, 3, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {ack, busy, err, rd[28:0]}, 32'h0);
        chk("reset_rd", rd, 32'h0);
        chk("reset_out0", {29'h0, ack0, busy0, err0}, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) issue(tbl[i]);

        // Reset during the wait state of a store must abort it cleanly.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; adr = AW'(9); off = 2'b00; size = 2'b11;
        wd = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_flags", {29'h0, ack, busy, err}, 32'h0);
        chk("abort_rd", rd, 32'h0);
        @(posedge clk); #1;
        rst  = 1'b0;
        hold = 32'h0;
        issue(mk(0, 9, 0, 3, 0, 32'h00000000, 3, 0));

        // Zero wait states: word store then two loads with req held high.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; adr0 = AW'(3); size0 = 2'b11; off0 = 2'b00;
        wd0 = 32'hCAFEF00D;
        n = 0;
        wait0(n);
        req0 = 1'b0;
        chk("w0_store_lat", 32'(n), 32'd2);
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; adr0 = AW'(3);
        n = 0;
        wait0(n);
        chk("w0_held_lat1", 32'(n), 32'd2);
        chk("w0_held_rd1", rd0, 32'hCAFEF00D);
        wait0(n);
        req0 = 1'b0;
        chk("w0_held_lat2", 32'(n), 32'd5);
        chk("w0_held_rd2", rd0, 32'hCAFEF00D);

        // A store pulse while busy must be ignored.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; adr0 = AW'(3);
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; wd0 = 32'h0;
        acks = ack0 ? 1 : 0;
        @(posedge clk); #1;
        req0 = 1'b0;
        if (ack0) acks++;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ack0) acks++;
        end
        chk("w0_pulse_acks", 32'(acks), 32'd1);
        req0 = 1'b1; we0 = 1'b0; adr0 = AW'(3);
        n = 0;
        wait0(n);
        req0 = 1'b0;
        chk("w0_after_pulse_lat", 32'(n), 32'd2);
        chk("w0_after_pulse_rd", rd0, 32'hCAFEF00D);
        chk("w0_err", {31'h0, err0}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
